// File: rtl/stage_ex_multicycle.sv
// Execute stage: ALU, shifts, compares, HI/LO ownership and multiply.
// Define STAGE_EX_DIVIDER_EN to build the iterative DIVU unit (stall-based).
module stage_ex_multicycle #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  valid_in,
   input  logic [2:0]            category,
   input  logic [7:0]            operator,
   input  logic [DATA_WIDTH-1:0] operand_a,
   input  logic [DATA_WIDTH-1:0] operand_b,
   input  logic [ADDR_WIDTH-1:0] result_address,
   input  logic                  destination_write_enable,
   output logic                  valid_out,
   output logic [DATA_WIDTH-1:0] result,
   output logic [ADDR_WIDTH-1:0] result_address_out,
   output logic                  write_enable_out,
   output logic                  stall,
   output logic [DATA_WIDTH-1:0] hi,
   output logic [DATA_WIDTH-1:0] lo
);

   localparam int SHW = $clog2(DATA_WIDTH);

   localparam logic [7:0] OP_SLL   = 8'h00;
   localparam logic [7:0] OP_SRL   = 8'h02;
   localparam logic [7:0] OP_SRA   = 8'h03;
   localparam logic [7:0] OP_MFHI  = 8'h10;
   localparam logic [7:0] OP_MTHI  = 8'h11;
   localparam logic [7:0] OP_MFLO  = 8'h12;
   localparam logic [7:0] OP_MTLO  = 8'h13;
   localparam logic [7:0] OP_MULTU = 8'h19;
   localparam logic [7:0] OP_DIVU  = 8'h1B;
   localparam logic [7:0] OP_ADDU  = 8'h21;
   localparam logic [7:0] OP_SUBU  = 8'h23;
   localparam logic [7:0] OP_AND   = 8'h24;
   localparam logic [7:0] OP_OR    = 8'h25;
   localparam logic [7:0] OP_XOR   = 8'h26;
   localparam logic [7:0] OP_NOR   = 8'h27;
   localparam logic [7:0] OP_SLT   = 8'h2A;
   localparam logic [7:0] OP_SLTU  = 8'h2B;

   logic                    valid_q;
   logic [DATA_WIDTH-1:0]   result_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic                    we_q;
   logic [DATA_WIDTH-1:0]   hi_q;
   logic [DATA_WIDTH-1:0]   lo_q;

   logic [DATA_WIDTH-1:0]   alu_res;
   logic                    wr_ok;
   logic                    hi_we;
   logic                    lo_we;
   logic [DATA_WIDTH-1:0]   hi_wd;
   logic [DATA_WIDTH-1:0]   lo_wd;
   logic                    div_start;
   logic [2*DATA_WIDTH-1:0] product;
   logic [SHW-1:0]          sa;

   logic                    stall_int;
   logic                    div_done;
   logic [DATA_WIDTH-1:0]   div_rem;
   logic [DATA_WIDTH-1:0]   div_quo;
   logic                    accept;

   assign sa      = operand_a[SHW-1:0];
   assign product = {{DATA_WIDTH{1'b0}}, operand_a} * {{DATA_WIDTH{1'b0}}, operand_b};
   assign accept  = valid_in & ~stall_int;

   always_comb begin
      alu_res   = '0;
      wr_ok     = 1'b1;
      hi_we     = 1'b0;
      lo_we     = 1'b0;
      hi_wd     = operand_a;
      lo_wd     = operand_a;
      div_start = 1'b0;
      if (category == 3'b000) begin
         wr_ok = 1'b0;
      end else begin
         case (operator)
            OP_OR:   alu_res = operand_a | operand_b;
            OP_AND:  alu_res = operand_a & operand_b;
            OP_XOR:  alu_res = operand_a ^ operand_b;
            OP_NOR:  alu_res = ~(operand_a | operand_b);
            OP_ADDU: alu_res = operand_a + operand_b;
            OP_SUBU: alu_res = operand_a - operand_b;
            OP_SLT:  alu_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(operand_a) < $signed(operand_b))};
            OP_SLTU: alu_res = {{(DATA_WIDTH-1){1'b0}}, (operand_a < operand_b)};
            OP_SLL:  alu_res = operand_b << sa;
            OP_SRL:  alu_res = operand_b >> sa;
            OP_SRA:  alu_res = $unsigned($signed(operand_b) >>> sa);
            OP_MFHI: alu_res = hi_q;
            OP_MFLO: alu_res = lo_q;
            OP_MTHI: begin
               wr_ok = 1'b0;
               hi_we = 1'b1;
            end
            OP_MTLO: begin
               wr_ok = 1'b0;
               lo_we = 1'b1;
            end
            OP_MULTU: begin
               wr_ok = 1'b0;
               hi_we = 1'b1;
               lo_we = 1'b1;
               hi_wd = product[2*DATA_WIDTH-1:DATA_WIDTH];
               lo_wd = product[DATA_WIDTH-1:0];
            end
`ifdef STAGE_EX_DIVIDER_EN
            OP_DIVU: begin
               wr_ok = 1'b0;
               // Divide by zero completes immediately: HI keeps the dividend, LO saturates.
               if (operand_b == '0) begin
                  hi_we = 1'b1;
                  lo_we = 1'b1;
                  hi_wd = operand_a;
                  lo_wd = '1;
               end else begin
                  div_start = 1'b1;
               end
            end
`endif
            default: wr_ok = 1'b0;
         endcase
      end
   end

`ifdef STAGE_EX_DIVIDER_EN
   typedef enum logic [1:0] {S_IDLE, S_DIVIDE, S_DONE} state_t;
   localparam logic [SHW-1:0] CNT_INIT = SHW'(DATA_WIDTH - 1);

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] rem_q, rem_d;
   logic [DATA_WIDTH-1:0] quo_q, quo_d;
   logic [DATA_WIDTH-1:0] dvs_q, dvs_d;
   logic [SHW-1:0]        cnt_q, cnt_d;
   logic [DATA_WIDTH:0]   trial;

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvs_d   = dvs_q;
      cnt_d   = cnt_q;
      trial   = {rem_q, quo_q[DATA_WIDTH-1]};
      case (state_q)
         S_IDLE: begin
            if (accept && div_start) begin
               state_d = S_DIVIDE;
               rem_d   = '0;
               quo_d   = operand_a;
               dvs_d   = operand_b;
               cnt_d   = CNT_INIT;
            end
         end
         S_DIVIDE: begin
            // quo_q shifts the dividend out at the top and the quotient in at the bottom.
            if (trial >= {1'b0, dvs_q}) begin
               rem_d = trial[DATA_WIDTH-1:0] - dvs_q;
               quo_d = {quo_q[DATA_WIDTH-2:0], 1'b1};
            end else begin
               rem_d = trial[DATA_WIDTH-1:0];
               quo_d = {quo_q[DATA_WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == '0) state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
   end

   assign stall_int = (state_q != S_IDLE);
   assign div_done  = (state_q == S_DONE);
   assign div_rem   = rem_q;
   assign div_quo   = quo_q;
`else
   assign stall_int = 1'b0;
   assign div_done  = 1'b0;
   assign div_rem   = '0;
   assign div_quo   = '0;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         valid_q  <= 1'b0;
         result_q <= '0;
         addr_q   <= '0;
         we_q     <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
      end else if (div_done) begin
         valid_q  <= 1'b1;
         result_q <= '0;
         we_q     <= 1'b0;
         hi_q     <= div_rem;
         lo_q     <= div_quo;
      end else if (stall_int) begin
         valid_q <= 1'b0;
      end else begin
         // A started divide retires later from the DONE state, not now.
         valid_q <= valid_in & ~div_start;
         if (valid_in) begin
            result_q <= alu_res;
            addr_q   <= result_address;
            we_q     <= wr_ok & destination_write_enable;
            if (hi_we) hi_q <= hi_wd;
            if (lo_we) lo_q <= lo_wd;
         end else begin
            we_q <= 1'b0;
         end
      end
   end

   assign valid_out          = valid_q;
   assign result             = result_q;
   assign result_address_out = addr_q;
   assign write_enable_out   = we_q;
   assign stall              = stall_int;
   assign hi                 = hi_q;
   assign lo                 = lo_q;

endmodule

// File: tb/tb_stage_ex_multicycle.sv
// Bench for stage_ex_multicycle: reference model plus directed literal checks.
// Divider scenarios are exercised when STAGE_EX_DIVIDER_EN is defined.
module tb_stage_ex_multicycle;

   logic        clock = 1'b0;
   logic        reset;
   logic        valid_in;
   logic [2:0]  category;
   logic [7:0]  operator;
   logic [31:0] operand_a;
   logic [31:0] operand_b;
   logic [4:0]  result_address;
   logic        destination_write_enable;
   logic        valid_out;
   logic [31:0] result;
   logic [4:0]  result_address_out;
   logic        write_enable_out;
   logic        stall;
   logic [31:0] hi;
   logic [31:0] lo;

   int vectors = 0;
   int miscompares = 0;

   stage_ex_multicycle #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
      .clock(clock), .reset(reset), .valid_in(valid_in), .category(category),
      .operator(operator), .operand_a(operand_a), .operand_b(operand_b),
      .result_address(result_address), .destination_write_enable(destination_write_enable),
      .valid_out(valid_out), .result(result), .result_address_out(result_address_out),
      .write_enable_out(write_enable_out), .stall(stall), .hi(hi), .lo(lo)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: architectural behaviour, division done with / and %.
   logic [31:0] m_res, m_hi, m_lo, p_hi, p_lo;
   logic [4:0]  m_addr;
   logic        m_valid, m_we, m_stall;
   logic [63:0] m_prod;
   bit          m_wr;
   bit          m_armed = 0;
   int          busy = 0;

   always @(posedge clock) begin
      if (reset) begin
         m_valid = 0; m_res = 0; m_addr = 0; m_we = 0; m_hi = 0; m_lo = 0;
         busy = 0; m_armed = 1;
      end else if (busy > 0) begin
         busy--;
         m_valid = 0;
         if (busy == 0) begin
            m_valid = 1; m_res = 0; m_we = 0; m_hi = p_hi; m_lo = p_lo;
         end
      end else begin
         m_valid = valid_in;
         m_we = 0;
         if (valid_in) begin
            m_addr = result_address;
            m_res = 0;
            m_wr = 1;
            if (category == 3'b000) m_wr = 0;
            else case (operator)
               8'h25: m_res = operand_a | operand_b;
               8'h24: m_res = operand_a & operand_b;
               8'h26: m_res = operand_a ^ operand_b;
               8'h27: m_res = ~(operand_a | operand_b);
               8'h21: m_res = operand_a + operand_b;
               8'h23: m_res = operand_a - operand_b;
               8'h2A: m_res = ($signed(operand_a) < $signed(operand_b)) ? 32'd1 : 32'd0;
               8'h2B: m_res = (operand_a < operand_b) ? 32'd1 : 32'd0;
               8'h00: m_res = operand_b << operand_a[4:0];
               8'h02: m_res = operand_b >> operand_a[4:0];
               8'h03: m_res = $signed(operand_b) >>> operand_a[4:0];
               8'h10: m_res = m_hi;
               8'h12: m_res = m_lo;
               8'h11: begin m_hi = operand_a; m_wr = 0; end
               8'h13: begin m_lo = operand_a; m_wr = 0; end
               8'h19: begin
                  m_prod = {32'b0, operand_a} * {32'b0, operand_b};
                  m_hi = m_prod[63:32]; m_lo = m_prod[31:0]; m_wr = 0;
               end
`ifdef STAGE_EX_DIVIDER_EN
               8'h1B: begin
                  m_wr = 0;
                  if (operand_b == 0) begin
                     m_hi = operand_a; m_lo = 32'hFFFF_FFFF;
                  end else begin
                     p_hi = operand_a % operand_b; p_lo = operand_a / operand_b;
                     busy = 33; m_valid = 0;
                  end
               end
`endif
               default: m_wr = 0;
            endcase
            m_we = m_wr & destination_write_enable;
         end
      end
      m_stall = (busy > 0);
   end

   always @(negedge clock) begin
      if (m_armed) begin
         chk("cyc_valid", {31'b0, valid_out}, {31'b0, m_valid});
         chk("cyc_stall", {31'b0, stall}, {31'b0, m_stall});
         chk("cyc_hi", hi, m_hi);
         chk("cyc_lo", lo, m_lo);
         if (m_valid) begin
            chk("cyc_result", result, m_res);
            chk("cyc_addr", {27'b0, result_address_out}, {27'b0, m_addr});
            chk("cyc_we", {31'b0, write_enable_out}, {31'b0, m_we});
         end
      end
   end

   task automatic drive(input logic [2:0] cat, input logic [7:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] ad, input logic we);
      valid_in = 1; category = cat; operator = op; operand_a = a; operand_b = b;
      result_address = ad; destination_write_enable = we;
   endtask

   task automatic issue(input logic [2:0] cat, input logic [7:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] ad, input logic we);
      @(negedge clock);
      drive(cat, op, a, b, ad, we);
      @(posedge clock); #1;
      valid_in = 0;
   endtask

   logic [7:0]  t_op [7];
   logic [31:0] t_a  [7];
   logic [31:0] t_b  [7];
   logic [31:0] t_r  [7];
   int          cnt;

   initial begin
      reset = 1; valid_in = 0; category = 0; operator = 0; operand_a = 0; operand_b = 0;
      result_address = 0; destination_write_enable = 0;
      repeat (2) @(posedge clock); #1;
      chk("rst_valid", {31'b0, valid_out}, 32'd0);
      chk("rst_result", result, 32'd0);
      chk("rst_stall", {31'b0, stall}, 32'd0);
      chk("rst_hi", hi, 32'd0);
      chk("rst_lo", lo, 32'd0);
      @(negedge clock) reset = 0;

      issue(3'b001, 8'h25, 32'h0000_F0F0, 32'h0000_0F0F, 5'd5, 1);
      chk("or_res", result, 32'h0000_FFFF);
      chk("or_we", {31'b0, write_enable_out}, 32'd1);
      chk("or_addr", {27'b0, result_address_out}, 32'd5);
      issue(3'b001, 8'h03, 32'd4, 32'h8000_0000, 5'd6, 1);
      chk("sra", result, 32'hF800_0000);
      issue(3'b001, 8'h2A, 32'hFFFF_FFFF, 32'd1, 5'd7, 1);
      chk("slt", result, 32'd1);
      issue(3'b001, 8'h2B, 32'hFFFF_FFFF, 32'd1, 5'd7, 1);
      chk("sltu", result, 32'd0);

      issue(3'b010, 8'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 1);
      chk("multu_hi", hi, 32'hFFFF_FFFE);
      chk("multu_lo", lo, 32'h0000_0001);
      chk("multu_we", {31'b0, write_enable_out}, 32'd0);
      issue(3'b010, 8'h10, 32'd0, 32'd0, 5'd9, 1);
      chk("mfhi", result, 32'hFFFF_FFFE);
      issue(3'b010, 8'h13, 32'h1234_ABCD, 32'd0, 5'd9, 1);
      issue(3'b010, 8'h12, 32'd0, 32'd0, 5'd9, 1);
      chk("mflo", result, 32'h1234_ABCD);

      // Back-to-back single-cycle ops, one per clock.
      t_op = '{8'h21, 8'h23, 8'h26, 8'h27, 8'h24, 8'h00, 8'h02};
      t_a  = '{32'hFFFF_FFFF, 32'd3, 32'hF0F0_F0F0, 32'd0, 32'h1234_5678, 32'd8, 32'd4};
      t_b  = '{32'd2, 32'd5, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0000_FFFF, 32'd1, 32'h8000_0000};
      t_r  = '{32'h1, 32'hFFFF_FFFE, 32'h0FF0_0FF0, 32'hF0F0_F0F0, 32'h0000_5678, 32'h100, 32'h0800_0000};
      for (int i = 0; i < 7; i++) begin
         issue(3'b001, t_op[i], t_a[i], t_b[i], 5'(i + 1), 1);
         chk("b2b_res", result, t_r[i]);
      end

      issue(3'b000, 8'h25, 32'hFF, 32'hFF, 5'd3, 1);
      chk("nop_valid", {31'b0, valid_out}, 32'd1);
      chk("nop_res", result, 32'd0);
      chk("nop_we", {31'b0, write_enable_out}, 32'd0);
      issue(3'b001, 8'hFF, 32'hFF, 32'hFF, 5'd3, 1);
      chk("unk_res", result, 32'd0);
      chk("unk_we", {31'b0, write_enable_out}, 32'd0);

`ifdef STAGE_EX_DIVIDER_EN
      issue(3'b011, 8'h1B, 32'd5, 32'd0, 5'd4, 1);
      chk("div0_stall", {31'b0, stall}, 32'd0);
      chk("div0_hi", hi, 32'd5);
      chk("div0_lo", lo, 32'hFFFF_FFFF);
      chk("div0_valid", {31'b0, valid_out}, 32'd1);

      issue(3'b011, 8'h1B, 32'd100, 32'd7, 5'd4, 1);
      drive(3'b001, 8'h25, 32'h0000_F0F0, 32'h0000_0F0F, 5'd11, 1);
      cnt = stall ? 1 : 0;
      for (int k = 0; k < 100 && stall; k++) begin
         @(posedge clock); #1;
         if (stall) cnt++;
      end
      chk("div_stall_cycles", cnt, 32'd33);
      chk("div_lo", lo, 32'd14);
      chk("div_hi", hi, 32'd2);
      chk("div_valid", {31'b0, valid_out}, 32'd1);
      @(posedge clock); #1;
      valid_in = 0;
      chk("post_div_or", result, 32'h0000_FFFF);
      chk("post_div_addr", {27'b0, result_address_out}, 32'd11);

      issue(3'b011, 8'h1B, 32'd1000, 32'd3, 5'd4, 1);
      repeat (9) @(posedge clock);
`else
      issue(3'b011, 8'h1B, 32'd100, 32'd7, 5'd4, 1);
      chk("divu_off_stall", {31'b0, stall}, 32'd0);
      chk("divu_off_hi", hi, 32'hFFFF_FFFE);
      chk("divu_off_lo", lo, 32'h1234_ABCD);
      chk("divu_off_we", {31'b0, write_enable_out}, 32'd0);
`endif
      @(negedge clock) reset = 1;
      @(posedge clock); #1;
      chk("mid_rst_stall", {31'b0, stall}, 32'd0);
      chk("mid_rst_hi", hi, 32'd0);
      chk("mid_rst_lo", lo, 32'd0);
      chk("mid_rst_valid", {31'b0, valid_out}, 32'd0);
      @(negedge clock) reset = 0;
      issue(3'b001, 8'h25, 32'h0000_F0F0, 32'h0000_0F0F, 5'd12, 1);
      chk("after_rst_or", result, 32'h0000_FFFF);
      chk("after_rst_hi", hi, 32'd0);

      repeat (3) @(posedge clock);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/stage_ex_multicycle.md
# stage_ex_multicycle

Parametrised execute stage for the in-order MIPS pipeline, sitting between the decode/ID-EX register and the memory stage. It takes decoded category/operator/operands, computes logic, arithmetic, shift, compare and HI/LO results, and registers them toward the memory stage. It owns the HI/LO register pair and an optional iterative unsigned divider, raising `stall` to freeze upstream stages while a division runs.

## Interface
- DATA_WIDTH, 32, operand/result width; power of two, ≥ 8
- ADDR_WIDTH, 5, register-file address width
- clock  in  1  rising-edge clock; the only clock
- reset  in  1  synchronous, active-high reset
- valid_in  in  1  decoded instruction present; sampled only when `stall`=0
- category  in  3  3'b000 = NOP; any other value = execute `operator`
- operator  in  8  operation code (Operation)
- operand_a  in  DATA_WIDTH  source A (rs); low log2(DATA_WIDTH) bits are the shift amount for shifts
- operand_b  in  DATA_WIDTH  source B (rt or immediate)
- result_address  in  ADDR_WIDTH  destination register
- destination_write_enable  in  1  instruction writes a GPR
- valid_out  out  1  registered result valid
- result  out  DATA_WIDTH  registered result
- result_address_out  out  ADDR_WIDTH  registered destination
- write_enable_out  out  1  registered GPR write enable
- stall  out  1  execute busy; upstream holds inputs
- hi, lo  out  DATA_WIDTH each  current HI/LO contents

## Operation
- Operators: 8'h25 OR, 8'h24 AND, 8'h26 XOR, 8'h27 NOR, 8'h21 ADDU (mod 2^DATA_WIDTH, no trap), 8'h23 SUBU (A−B mod 2^DATA_WIDTH), 8'h2A SLT (signed A<B → 1 else 0), 8'h2B SLTU (unsigned), 8'h00 SLL (B<<sa), 8'h02 SRL (B>>sa logical), 8'h03 SRA (arithmetic), 8'h10 MFHI, 8'h12 MFLO, 8'h11 MTHI (HI←A), 8'h13 MTLO (LO←A), 8'h19 MULTU ({HI,LO}←A×B unsigned, 2·DATA_WIDTH product), 8'h1B DIVU (LO←A/B, HI←A%B).
- Unknown operator or category=000: result 0, write_enable_out 0, valid_out follows valid_in.
- MTHI/MTLO/MULTU/DIVU: write_enable_out forced 0, result 0.
- Single-cycle ops: on an edge with valid_in=1, stall=0, outputs load; write_enable_out = destination_write_enable.
- Divider FSM: IDLE → DIVIDE on accepted DIVU with B≠0; restoring radix-2, one quotient bit per cycle, counter DATA_WIDTH−1 down to 0; DIVIDE → DONE when counter reaches 0; DONE → IDLE next cycle, writing HI/LO and asserting valid_out.
- DIVU with B=0: no iteration; same edge sets HI←A, LO←all ones, valid_out=1.
- stall = 1 in DIVIDE and DONE; while stall=1 inputs are ignored and valid_out=0.
- HI/LO writes take effect at the accepting edge (DIVU: DONE edge); the next accepted MFHI/MFLO sees the new value.
- Reset: valid_out, result, result_address_out, write_enable_out, hi, lo = 0; FSM → IDLE; stall = 0. Reset during DIVIDE/DONE aborts the divide with no HI/LO update.

## Timing
- Single-cycle ops: latency 1; throughput 1 per clock.
- DIVU (B≠0): accepted at edge 0; stall high from edge 0 to edge DATA_WIDTH+1; HI/LO and valid_out update at edge DATA_WIDTH+1; stall low after it; next instruction accepted at edge DATA_WIDTH+2. That is 32+2 cycles at default.
- stall is a registered state decode; it has no combinational path from inputs.

## Configuration
- `STAGE_EX_DIVIDER_EN` defined: divider FSM and DIVU as above.
- Undefined: no divider logic. DIVU behaves as an unknown operator: HI/LO unchanged, single cycle. stall is tied to 0.

## Test plan
- A=32'h0000_F0F0, B=32'h0000_0F0F, OR → result 32'h0000_FFFF one cycle after acceptance, write_enable_out=1, address echoed.
- SRA, B=32'h8000_0000, A=4 → 32'hF800_0000; SLT A=32'hFFFF_FFFF, B=1 → 1; SLTU same operands → 0.
- MULTU A=B=32'hFFFF_FFFF → HI=32'hFFFF_FFFE, LO=32'h0000_0001; following MFHI → 32'hFFFF_FFFE.
- DIVU A=100, B=7 (divider enabled) → stall high 33 cycles; then LO=14, HI=2. Back-to-back OR held on the inputs retires one cycle after stall drops.
- DIVU B=0, A=5 → no stall, HI=5, LO=32'hFFFF_FFFF.
- Reset asserted at divide cycle 10 → stall=0, hi=lo=0, valid_out=0 next cycle; a new OR executes normally.
